// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// States, hazard priority codes and the register-index width.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    ERR
  } state_t;

  // Hazard classes, ordered so a larger code wins.
  localparam logic [1:0] HZ_NONE   = 2'd0;
  localparam logic [1:0] HZ_LOAD   = 2'd1;
  localparam logic [1:0] HZ_BRANCH = 2'd2;
  localparam logic [1:0] HZ_FREEZE = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with asynchronous active-low reset.
// Counts edges where inc is high and holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch,
// memory-wait freeze, bus watchdog and stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadE,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] Rs1_D,
  input  logic [REG_W-1:0] Rs2_D,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             BusErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      stateNext;
  logic [15:0] WaitCnt;
  logic [1:0]  hazard;
  logic        pending;
  logic        loadUse;

  assign pending = MemReqM & ~MemReadyM;
  assign loadUse = MemReadE && (RdE != '0) &&
                   ((RdE == Rs1_D) || (RdE == Rs2_D));

  always_comb begin
    hazard = HZ_NONE;
    if (!rst) begin
      hazard = HZ_NONE;
    end else if (pending || (state == ERR)) begin
      hazard = HZ_FREEZE;
    end else if (PCSrcE) begin
      hazard = HZ_BRANCH;
    end else if (loadUse) begin
      hazard = HZ_LOAD;
    end
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    unique case (hazard)
      HZ_FREEZE: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end
      HZ_BRANCH: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      HZ_LOAD: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      default: ;
    endcase
  end

  // A ready on the last allowed edge clears pending, so RUN wins.
  always_comb begin
    stateNext = state;
    unique case (state)
      RUN: begin
        if (pending) begin
          stateNext = (WaitCnt == WAIT_LAST) ? ERR : WAIT;
        end
      end
      WAIT: begin
        if (!pending) begin
          stateNext = RUN;
        end else if (WaitCnt == WAIT_LAST) begin
          stateNext = ERR;
        end
      end
      ERR:     stateNext = ERR;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      WaitCnt <= '0;
      BusErr  <= 1'b0;
    end else begin
      state  <= stateNext;
      BusErr <= BusErr | (stateNext == ERR);
      if (!pending) begin
        WaitCnt <= '0;
      end else if (WaitCnt != 16'hFFFF) begin
        WaitCnt <= WaitCnt + 16'd1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (StallF),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hazard == HZ_BRANCH),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// Runs with TIMEOUT_CYCLES=4 and CNT_W=3 to reach watchdog and saturation.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       MemReadE = 1'b0;
  logic [4:0] RdE = '0;
  logic [4:0] Rs1_D = '0;
  logic [4:0] Rs2_D = '0;
  logic       PCSrcE = 1'b0;
  logic       MemReqM = 1'b0;
  logic       MemReadyM = 1'b0;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic       BusErr;
  logic [2:0] StallCnt, FlushCnt;

  int tests = 0;
  int fails = 0;

  pipeline_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemReadE  (MemReadE),
    .RdE       (RdE),
    .Rs1_D     (Rs1_D),
    .Rs2_D     (Rs2_D),
    .PCSrcE    (PCSrcE),
    .MemReqM   (MemReqM),
    .MemReadyM (MemReadyM),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushW    (FlushW),
    .BusErr    (BusErr),
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic idle();
    MemReadE = 0; RdE = 0; Rs1_D = 0; Rs2_D = 0;
    PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    idle();
    #2;
    @(negedge clk);
    rst = 1;
    step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0;
    MemReadE = 1; RdE = 5; Rs1_D = 5; PCSrcE = 1; MemReqM = 1;
    #1;
    tests++;
    if (ctl() !== 7'b0) begin
      fails++; $display("FAIL reset_ctl got %b exp %b", ctl(), 7'b0);
    end
    tests++;
    if ({BusErr, StallCnt, FlushCnt} !== 7'b0) begin
      fails++;
      $display("FAIL reset_regs got %b exp %b", {BusErr, StallCnt, FlushCnt}, 7'b0);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    MemReadE = 1; RdE = 5; Rs2_D = 5; Rs1_D = 1;
    #1;
    tests++;
    if (ctl() !== 7'b1100010) begin
      fails++; $display("FAIL lu_rs2 got %b exp %b", ctl(), 7'b1100010);
    end
    step();
    idle();
    #1;
    tests++;
    if (ctl() !== 7'b0) begin
      fails++; $display("FAIL lu_after got %b exp %b", ctl(), 7'b0);
    end
    tests++;
    if (StallCnt !== 3'd1) begin
      fails++; $display("FAIL lu_cnt got %0d exp %0d", StallCnt, 1);
    end
    MemReadE = 1; RdE = 3; Rs1_D = 3;
    #1;
    tests++;
    if (ctl() !== 7'b1100010) begin
      fails++; $display("FAIL lu_rs1 got %b exp %b", ctl(), 7'b1100010);
    end
    MemReadE = 1; RdE = 0; Rs1_D = 0; Rs2_D = 0;
    #1;
    tests++;
    if (ctl() !== 7'b0) begin
      fails++; $display("FAIL lu_x0 got %b exp %b", ctl(), 7'b0);
    end
    MemReadE = 0; RdE = 9; Rs1_D = 9;
    #1;
    tests++;
    if (ctl() !== 7'b0) begin
      fails++; $display("FAIL lu_noload got %b exp %b", ctl(), 7'b0);
    end
    step();
    tests++;
    if (StallCnt !== 3'd1) begin
      fails++; $display("FAIL lu_cnt_hold got %0d exp %0d", StallCnt, 1);
    end
    idle();
  endtask

  task automatic test_branch_load_use();
    do_reset();
    PCSrcE = 1; MemReadE = 1; RdE = 7; Rs1_D = 7;
    #1;
    tests++;
    if (ctl() !== 7'b0000110) begin
      fails++; $display("FAIL br_lu got %b exp %b", ctl(), 7'b0000110);
    end
    step();
    idle();
    #1;
    tests++;
    if ({FlushCnt, StallCnt} !== {3'd1, 3'd0}) begin
      fails++;
      $display("FAIL br_cnts got %0d/%0d exp 1/0", FlushCnt, StallCnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (ctl() !== 7'b1111001) begin
        fails++; $display("FAIL mw_freeze%0d got %b exp %b", i, ctl(), 7'b1111001);
      end
      step();
    end
    MemReadyM = 1;
    #1;
    tests++;
    if (ctl() !== 7'b0000110) begin
      fails++; $display("FAIL mw_ready got %b exp %b", ctl(), 7'b0000110);
    end
    step();
    idle();
    #1;
    tests++;
    if ({ctl(), BusErr} !== 8'b0) begin
      fails++; $display("FAIL mw_run got %b exp %b", {ctl(), BusErr}, 8'b0);
    end
    tests++;
    if ({StallCnt, FlushCnt} !== {3'd3, 3'd1}) begin
      fails++;
      $display("FAIL mw_cnts got %0d/%0d exp 3/1", StallCnt, FlushCnt);
    end
    MemReqM = 1; MemReadyM = 1;
    #1;
    tests++;
    if (StallF !== 1'b0) begin
      fails++; $display("FAIL mw_zero got %b exp %b", StallF, 1'b0);
    end
    step();
    idle();
  endtask

  task automatic test_watchdog();
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (BusErr !== (i == 4)) begin
        fails++; $display("FAIL wd_edge%0d got %b exp %b", i, BusErr, (i == 4));
      end
    end
    MemReqM = 0; MemReadyM = 1;
    #1;
    tests++;
    if (ctl() !== 7'b1111001) begin
      fails++; $display("FAIL wd_err_freeze got %b exp %b", ctl(), 7'b1111001);
    end
    step();
    step();
    tests++;
    if ({BusErr, StallF} !== 2'b11) begin
      fails++; $display("FAIL wd_sticky got %b exp %b", {BusErr, StallF}, 2'b11);
    end
    #1;
    rst = 0;
    #1;
    tests++;
    if ({ctl(), BusErr} !== 8'b0) begin
      fails++; $display("FAIL wd_rst got %b exp %b", {ctl(), BusErr}, 8'b0);
    end
    @(negedge clk);
    rst = 1;
    idle();
    step();
    tests++;
    if ({ctl(), BusErr} !== 8'b0) begin
      fails++; $display("FAIL wd_run got %b exp %b", {ctl(), BusErr}, 8'b0);
    end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    step();
    step();
    step();
    MemReadyM = 1;
    #1;
    tests++;
    if (StallF !== 1'b0) begin
      fails++; $display("FAIL tb_ready got %b exp %b", StallF, 1'b0);
    end
    step();
    idle();
    #1;
    tests++;
    if ({BusErr, StallF} !== 2'b00) begin
      fails++; $display("FAIL tb_noerr got %b exp %b", {BusErr, StallF}, 2'b00);
    end
    MemReqM = 1;
    step();
    step();
    step();
    tests++;
    if ({BusErr, StallF} !== 2'b01) begin
      fails++; $display("FAIL tb_rewait got %b exp %b", {BusErr, StallF}, 2'b01);
    end
    step();
    tests++;
    if (BusErr !== 1'b1) begin
      fails++; $display("FAIL tb_rewait_err got %b exp %b", BusErr, 1'b1);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    MemReadE = 1; RdE = 4; Rs1_D = 4;
    step();
    MemReadE = 1; RdE = 6; Rs2_D = 6; Rs1_D = 0;
    #1;
    tests++;
    if (ctl() !== 7'b1100010) begin
      fails++; $display("FAIL b2b_lu got %b exp %b", ctl(), 7'b1100010);
    end
    step();
    MemReadE = 0; PCSrcE = 1;
    step();
    PCSrcE = 1;
    step();
    idle();
    #1;
    tests++;
    if ({StallCnt, FlushCnt} !== {3'd2, 3'd2}) begin
      fails++;
      $display("FAIL b2b_cnts got %0d/%0d exp 2/2", StallCnt, FlushCnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    MemReadE = 1; RdE = 2; Rs2_D = 2;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests++;
      if (StallCnt !== ((k > 7) ? 3'd7 : 3'(k))) begin
        fails++;
        $display("FAIL sat_k%0d got %0d exp %0d", k, StallCnt, (k > 7) ? 7 : k);
      end
    end
    #1;
    rst = 0;
    #1;
    tests++;
    if ({ctl(), StallCnt, FlushCnt, BusErr} !== 14'b0) begin
      fails++;
      $display("FAIL sat_async_rst got %b exp %b",
               {ctl(), StallCnt, FlushCnt, BusErr}, 14'b0);
    end
    @(negedge clk);
    idle();
    rst = 1;
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_watchdog();
    test_timeout_boundary();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It sits beside the forwarding logic and resolves the hazards forwarding cannot: load-use dependencies, taken branches/jumps, and multi-cycle data-memory accesses. It drives stall and flush enables to the F/D, D/E, E/M and M/W pipeline registers. It also keeps a memory-wait watchdog and saturating stall/flush performance counters.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: consecutive frozen cycles before a bus error is declared (range 1..2^16-1).
- CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemReadE  in  1  instruction in E is a load.
- RdE  in  5  destination register of the instruction in E.
- Rs1_D, Rs2_D  in  5 each  source registers of the instruction in D.
- PCSrcE  in  1  taken branch/jump resolved in E.
- MemReqM  in  1  instruction in M is accessing data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into the D, E or W register.
- BusErr  out  1  sticky watchdog error.
- StallCnt, FlushCnt  out  CNT_W each  performance counters.

## Operation
- States: RUN, WAIT, ERR. Reset state is RUN.
- freeze = MemReqM & !MemReadyM, or state == ERR.
- Priority, highest first:
  1. **freeze:** StallF = StallD = StallE = StallM = 1 and FlushW = 1. FlushW prevents a duplicate writeback. All other outputs are 0. Any pending branch or load-use is deferred, because E is held.
  2. **branch (PCSrcE):** FlushD = FlushE = 1, no stalls. This also covers a simultaneous load-use, since the D instruction is squashed.
  3. **load-use:** triggers when MemReadE & (RdE != 0) & (RdE == Rs1_D | RdE == Rs2_D). Drive StallF = StallD = 1 and FlushE = 1.
  4. **otherwise:** all stall and flush outputs are 0.
- FSM transitions:
  - RUN → WAIT when MemReqM & !MemReadyM.
  - WAIT → RUN when MemReadyM.
  - WAIT → ERR on the edge where the wait is still pending and WaitCnt == TIMEOUT_CYCLES-1.
  - ERR is exited only by reset.
- WaitCnt (16 bits, internal):
  - Increments on every edge at which MemReqM & !MemReadyM holds.
  - Clears on any edge where that condition is false.
  - Entry into ERR sets BusErr = 1, and BusErr stays set.
- StallCnt increments on every edge where StallF = 1.
- FlushCnt increments on every edge where a branch flush (rule 2) is active.
- Both counters saturate at all-ones and never wrap.
- While rst = 0: every stall/flush output is 0, state is RUN, and WaitCnt, StallCnt, FlushCnt and BusErr are all 0. Reset asserted mid-WAIT or in ERR returns to RUN immediately (asynchronously).

## Timing
- Stall and flush outputs are combinational (Mealy) from the current inputs and the registered state. There is zero-cycle latency from hazard to stall within the same cycle.
- Load-use inserts exactly one bubble. The cycle after the stall, the load is in M, the hazard condition is false, and forwarding supplies the data.
- A branch costs 2 squashed instructions and 1 cycle of flush assertion.
- A memory access with ready after N cycles freezes the pipeline for exactly N cycles. MemReadyM in the first request cycle gives 0 freeze cycles.
- Timeout: after exactly TIMEOUT_CYCLES consecutive frozen cycles without ready, state is ERR and BusErr is high from the following cycle onward. A MemReadyM arriving on that same edge wins: the next state is RUN and no error is raised.
- Counters, state and BusErr update only on clk edges (besides async reset). Counter values are visible the cycle after the counted event.

## Structure
- A shared package pipeline_ctrl_pkg holds:
  - the state enum (RUN, WAIT, ERR);
  - the hazard-priority localparams;
  - the register-index width constant (5).
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count), is instantiated twice for StallCnt and FlushCnt.
- WaitCnt and the FSM stay in the top module.

## Test plan
- **Load-use:** with MemReadE=1, RdE=5, Rs2_D=5 for 1 cycle → StallF=StallD=FlushE=1 that cycle only, StallCnt=1 next cycle. Repeat with RdE=0 → no stall.
- **Branch plus load-use same cycle:** PCSrcE=1, MemReadE=1, RdE=Rs1_D=7 → FlushD=FlushE=1, StallF=0, FlushCnt increments by 1.
- **Memory wait:** MemReqM=1 with MemReadyM low for 3 cycles, then high → StallF..StallM=FlushW=1 for exactly 3 cycles, state returns to RUN, BusErr=0. PCSrcE=1 held throughout produces no flush until the freeze ends.
- **Watchdog:** with TIMEOUT_CYCLES=4, MemReqM=1 and MemReadyM never asserted → BusErr=1 after the 4th edge and freeze persists. Asserting MemReadyM afterwards has no effect. Pulsing rst=0 clears to RUN and BusErr=0.
- **Timeout boundary:** with TIMEOUT_CYCLES=4 and MemReadyM rising exactly on the 4th frozen cycle → RUN, BusErr=0.
- **Saturation and async reset:** with CNT_W=3 and continuous load-use for 10 cycles → StallCnt holds at 7. Asserting rst mid-stall, between edges → all outputs 0 immediately.
